// File: rtl/prior_pkg.sv
// Shared constants and helpers for the registered priority arbiter.
package prior_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Value the rotating pointer takes out of reset: the top index, so the
  // first round-robin pass behaves like fixed priority.
  function automatic int unsigned reset_ptr(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/prior_arb_if.sv
// Request/grant handshake bundle between request sources and prior_arb.
interface prior_arb_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) ();

  logic         mode;
  logic [N-1:0] req;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic         grant_zero;
  logic         grant_valid;
  logic         grant_ready;

  // Request source / result consumer side
  modport master (
    output mode, req, req_valid, grant_ready,
    input  req_ready, grant_idx, grant_onehot, grant_zero, grant_valid
  );

  // Arbiter side
  modport slave (
    input  mode, req, req_valid, grant_ready,
    output req_ready, grant_idx, grant_onehot, grant_zero, grant_valid
  );

endinterface

// File: rtl/prior_find.sv
// Combinational search for the highest set request bit at or below start,
// wrapping from index 0 back to N-1.
module prior_find
  import prior_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         zero
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int unsigned    hi;

  // Doubled vector: upper copy covers start..0, lower copy supplies the wrap
  // N-1..start+1. Bits above start+N are masked, so the highest survivor
  // is the winner, reduced modulo N.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    hi     = 0;
    zero   = ~|req;
    idx    = '0;
    onehot = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (i <= 32'(start) + N) masked[i] = dbl[i];
    end
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (masked[i]) hi = i;
    end
    if (!zero) begin
      idx = (hi >= N) ? W'(hi - N) : W'(hi);
      for (int unsigned i = 0; i < N; i++) begin
        onehot[i] = (idx == W'(i));
      end
    end
  end

endmodule

// File: rtl/prior_arb.sv
// Registered priority encoder/arbiter: fixed-priority or round-robin winner
// selection over a valid/ready handshake, result one cycle after accept.
module prior_arb
  import prior_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input logic       clk,
  input logic       rst,
  prior_arb_if.slave bus
);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] f_idx;
  logic [N-1:0] f_onehot;
  logic         f_zero;
  logic         accept;

  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;
  logic         zero_q;
  logic         valid_q;

  // Handshake: the output register may reload on the cycle it drains.
  always_comb begin
    bus.req_ready = !valid_q || bus.grant_ready;
    accept        = bus.req_valid && bus.req_ready;
    start         = (bus.mode == MODE_RR) ? ptr : W'(N - 1);
  end

  prior_find #(
    .N (N),
    .W (W)
  ) u_find (
    .req    (bus.req),
    .start  (start),
    .idx    (f_idx),
    .onehot (f_onehot),
    .zero   (f_zero)
  );

  // Output register and rotating pointer; both frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      onehot_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      ptr      <= W'(reset_ptr(N));
    end else if (accept) begin
      idx_q    <= f_idx;
      onehot_q <= f_onehot;
      zero_q   <= f_zero;
      valid_q  <= 1'b1;
      if (bus.mode == MODE_RR && !f_zero) begin
        ptr <= (f_idx == '0) ? W'(N - 1) : f_idx - W'(1);
      end
    end else if (bus.grant_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Drive the registered result onto the bus.
  always_comb begin
    bus.grant_idx    = idx_q;
    bus.grant_onehot = onehot_q;
    bus.grant_zero   = zero_q;
    bus.grant_valid  = valid_q;
  end

endmodule

// File: tb/tb_prior_arb.sv
// Directed and model-checked bench for prior_arb (N=4 and N=8 instances).
module tb_prior_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  prior_arb_if #(.N(4)) a4 ();
  prior_arb_if #(.N(8)) b8 ();

  prior_arb #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(a4));
  prior_arb #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (a4.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", a4.grant_valid); end
    checks++; if (a4.grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", a4.grant_idx); end
    checks++; if (a4.grant_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot got=%b exp=0000", a4.grant_onehot); end
    checks++; if (a4.grant_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", a4.grant_zero); end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (a4.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", a4.req_ready); end
  endtask

  task automatic test_fixed_stream();
    logic [3:0] vec [5];
    int         exp [5];
    logic [3:0] oh;
    vec = '{4'b0010, 4'b1010, 4'b0011, 4'b0110, 4'b0111};
    exp = '{1, 3, 1, 2, 2};
    a4.mode = 1'b0; a4.grant_ready = 1'b1; a4.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a4.req = vec[k];
      step();
      oh = 4'b0001 << exp[k];
      checks++; if (a4.grant_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid[%0d] got=%b exp=1", k, a4.grant_valid); end
      checks++; if (a4.grant_idx !== 2'(exp[k])) begin errors++; $display("FAIL fixed_idx[%0d] got=%0d exp=%0d", k, a4.grant_idx, exp[k]); end
      checks++; if (a4.grant_onehot !== oh) begin errors++; $display("FAIL fixed_onehot[%0d] got=%b exp=%b", k, a4.grant_onehot, oh); end
    end
    a4.req_valid = 1'b0;
    step();
    checks++; if (a4.grant_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got=%b exp=0", a4.grant_valid); end
  endtask

  task automatic test_zero();
    a4.mode = 1'b0; a4.req = 4'b0000; a4.req_valid = 1'b1; a4.grant_ready = 1'b1;
    step();
    a4.req_valid = 1'b0;
    checks++; if (a4.grant_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", a4.grant_valid); end
    checks++; if (a4.grant_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got=%b exp=1", a4.grant_zero); end
    checks++; if (a4.grant_idx !== 2'd0) begin errors++; $display("FAIL zero_idx got=%0d exp=0", a4.grant_idx); end
    checks++; if (a4.grant_onehot !== 4'b0000) begin errors++; $display("FAIL zero_onehot got=%b exp=0000", a4.grant_onehot); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] vec [4];
    int         exp [4];
    vec = '{4'b1010, 4'b1010, 4'b1010, 4'b1111};
    exp = '{3, 1, 3, 2};
    a4.mode = 1'b1; a4.grant_ready = 1'b1; a4.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a4.req = vec[k];
      step();
      checks++; if (a4.grant_idx !== 2'(exp[k]) || a4.grant_valid !== 1'b1 || a4.grant_zero !== 1'b0)
        begin errors++; $display("FAIL rr_idx[%0d] got=%0d/v%b exp=%0d/v1", k, a4.grant_idx, a4.grant_valid, exp[k]); end
    end
    a4.req_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    // ptr is 1 here; 1111 grants 1 and moves ptr to 0.
    a4.mode = 1'b1; a4.req = 4'b1111; a4.req_valid = 1'b1; a4.grant_ready = 1'b1;
    step();
    checks++; if (a4.grant_idx !== 2'd1) begin errors++; $display("FAIL bp_first got=%0d exp=1", a4.grant_idx); end
    a4.grant_ready = 1'b0; a4.req = 4'b1001;
    #1;
    checks++; if (a4.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0 got=%b exp=0", a4.req_ready); end
    for (int k = 0; k < 3; k++) begin
      a4.mode = k[0];
      a4.req  = (k == 1) ? 4'b0100 : 4'b1001;
      step();
      checks++; if (a4.req_ready !== 1'b0 || a4.grant_valid !== 1'b1 || a4.grant_idx !== 2'd1 || a4.grant_onehot !== 4'b0010)
        begin errors++; $display("FAIL bp_hold[%0d] got=r%b v%b i%0d o%b exp=r0 v1 i1 o0010", k, a4.req_ready, a4.grant_valid, a4.grant_idx, a4.grant_onehot); end
    end
    // With ptr still 0, 1001 grants 0; a moved ptr would grant 3.
    a4.mode = 1'b1; a4.req = 4'b1001; a4.grant_ready = 1'b1;
    step();
    checks++; if (a4.grant_valid !== 1'b1 || a4.grant_idx !== 2'd0 || a4.grant_onehot !== 4'b0001)
      begin errors++; $display("FAIL bp_release got=v%b i%0d o%b exp=v1 i0 o0001", a4.grant_valid, a4.grant_idx, a4.grant_onehot); end
    a4.req = 4'b0011;
    step();
    checks++; if (a4.grant_valid !== 1'b1 || a4.grant_idx !== 2'd1)
      begin errors++; $display("FAIL bp_b2b got=v%b i%0d exp=v1 i1", a4.grant_valid, a4.grant_idx); end
    a4.req_valid = 1'b0;
    step();
    checks++; if (a4.grant_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", a4.grant_valid); end
  endtask

  task automatic test_reset_mid();
    // ptr is 0; 1000 grants 3 and leaves ptr at 2.
    a4.mode = 1'b1; a4.req = 4'b1000; a4.req_valid = 1'b1; a4.grant_ready = 1'b1;
    step();
    a4.req_valid = 1'b0; a4.grant_ready = 1'b0;
    step();
    checks++; if (a4.grant_valid !== 1'b1 || a4.grant_idx !== 2'd3)
      begin errors++; $display("FAIL mid_stall got=v%b i%0d exp=v1 i3", a4.grant_valid, a4.grant_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a4.grant_valid !== 1'b0 || a4.grant_idx !== 2'd0 || a4.grant_onehot !== 4'b0000 || a4.grant_zero !== 1'b0)
      begin errors++; $display("FAIL mid_async got=v%b i%0d o%b z%b exp=all0", a4.grant_valid, a4.grant_idx, a4.grant_onehot, a4.grant_zero); end
    checks++; if (a4.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", a4.req_ready); end
    step();
    rst = 1'b0;
    a4.grant_ready = 1'b1; a4.mode = 1'b1; a4.req = 4'b1111; a4.req_valid = 1'b1;
    step();
    checks++; if (a4.grant_idx !== 2'd3 || a4.grant_valid !== 1'b1)
      begin errors++; $display("FAIL mid_ptr got=v%b i%0d exp=v1 i3", a4.grant_valid, a4.grant_idx); end
    step();
    checks++; if (a4.grant_idx !== 2'd2) begin errors++; $display("FAIL mid_next got=%0d exp=2", a4.grant_idx); end
    a4.req_valid = 1'b0;
    step();
  endtask

  task automatic test_random8();
    logic       m_valid, m_zero;
    logic [2:0] m_idx, m_ptr, st, j;
    logic [7:0] m_oh;
    logic       exp_rdy, found;
    m_valid = 1'b0; m_zero = 1'b0; m_idx = '0; m_ptr = 3'd7; m_oh = '0;
    for (int n = 0; n < 10000; n++) begin
      b8.req         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b8.mode        = 1'($urandom);
      b8.req_valid   = ($urandom_range(0, 3) != 0);
      b8.grant_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !m_valid || b8.grant_ready;
      checks++; if (b8.req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, b8.req_ready, exp_rdy); end
      if (b8.req_valid && exp_rdy) begin
        st = b8.mode ? m_ptr : 3'd7;
        found = 1'b0;
        m_idx = '0;
        for (int k = 0; k < 8; k++) begin
          j = st - 3'(k);
          if (!found && b8.req[j]) begin found = 1'b1; m_idx = j; end
        end
        m_zero  = !found;
        m_oh    = found ? (8'b1 << m_idx) : 8'h00;
        m_valid = 1'b1;
        if (b8.mode && found) m_ptr = m_idx - 3'd1;
      end else if (b8.grant_ready) begin
        m_valid = 1'b0;
      end
      step();
      checks++;
      if (b8.grant_valid !== m_valid || b8.grant_idx !== m_idx || b8.grant_onehot !== m_oh || b8.grant_zero !== m_zero) begin
        errors++;
        $display("FAIL rand_out[%0d] got=v%b i%0d o%b z%b exp=v%b i%0d o%b z%b", n,
                 b8.grant_valid, b8.grant_idx, b8.grant_onehot, b8.grant_zero, m_valid, m_idx, m_oh, m_zero);
      end
    end
    b8.req_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    a4.mode = 1'b0; a4.req = '0; a4.req_valid = 1'b0; a4.grant_ready = 1'b1;
    b8.mode = 1'b0; b8.req = '0; b8.req_valid = 1'b0; b8.grant_ready = 1'b1;
    #1;
    test_reset();
    test_fixed_stream();
    test_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
